// File: rtl/seg_scan.sv
// seg_scan: four-digit time-multiplexed 7-segment scanner.
// segclk is treated as an asynchronous data input. It is synchronised and
// edge-detected, and each rising edge steps the scan to the next digit.
// Between digits there is a fixed blanking gap. The displayed value is
// latched into a shadow register only at frame boundaries.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | display dark; waits for enable, then loads shadow and starts
//   BLANK | all anodes off for BLANK_CYCLES clocks after a digit advance
//   DRIVE | one anode low, decoded cathodes driven; waits for a segclk tick
module seg_scan #(
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        segclk,
  input  logic        enable,
  input  logic [15:0] value,
  input  logic [3:0]  dp_mask,
  input  logic        blank_lead,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [1:0]  digit_idx,
  output logic        frame_tick
);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  localparam logic [7:0] BLANK_LOAD = 8'(BLANK_CYCLES);

  state_t      state;
  logic [7:0]  cnt;
  logic [15:0] shadow;
  logic        s1, s2, s3;
  logic        tick;
  logic [3:0]  nib;
  logic        lz;
  logic [6:0]  drive_seg;
  logic [3:0]  an_drive;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  // Two-flop synchroniser for segclk plus a history flop for edge detection.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= segclk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick = s2 & ~s3;

  // Select the shadow nibble for the current digit, and detect the leading-zero run.
  always_comb begin
    nib = shadow[3:0];
    lz  = 1'b0;
    case (digit_idx)
      2'd0: begin nib = shadow[3:0];   lz = 1'b0;                  end
      2'd1: begin nib = shadow[7:4];   lz = (shadow[15:4] == '0);  end
      2'd2: begin nib = shadow[11:8];  lz = (shadow[15:8] == '0);  end
      default: begin nib = shadow[15:12]; lz = (shadow[15:12] == '0); end
    endcase
  end

  assign drive_seg = (blank_lead && lz) ? 7'h7F : decode(nib);
  assign an_drive  = ~(4'b0001 << digit_idx);

  // Scan FSM with registered outputs. Cathodes are also released during the gap.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state      <= IDLE;
      cnt        <= '0;
      shadow     <= '0;
      an         <= 4'hF;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      digit_idx  <= 2'd0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (!enable) begin
        state     <= IDLE;
        cnt       <= '0;
        an        <= 4'hF;
        seg       <= 7'h7F;
        dp        <= 1'b1;
        digit_idx <= 2'd0;
      end else begin
        case (state)
          IDLE: begin
            an         <= 4'hF;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            digit_idx  <= 2'd0;
            shadow     <= value;
            frame_tick <= 1'b1;
            cnt        <= BLANK_LOAD;
            state      <= BLANK;
          end
          BLANK: begin
            cnt <= cnt - 8'd1;
            if (cnt <= 8'd1) begin
              state <= DRIVE;
              an    <= an_drive;
              seg   <= drive_seg;
              dp    <= ~dp_mask[digit_idx];
            end else begin
              an  <= 4'hF;
              seg <= 7'h7F;
              dp  <= 1'b1;
            end
          end
          DRIVE: begin
            if (tick) begin
              digit_idx <= digit_idx + 2'd1;
              an        <= 4'hF;
              seg       <= 7'h7F;
              dp        <= 1'b1;
              cnt       <= BLANK_LOAD;
              state     <= BLANK;
              if (digit_idx == 2'd3) begin
                shadow     <= value;
                frame_tick <= 1'b1;
              end
            end else begin
              an  <= an_drive;
              seg <= drive_seg;
              dp  <= ~dp_mask[digit_idx];
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: expected digits are queued as stimulus is issued and
// compared when the DUT starts driving a digit.
module tb_seg_scan;

  localparam int BLANK = 4;

  logic        clk = 1'b0;
  logic        clr;
  logic        segclk;
  logic        enable;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic        blank_lead;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] idx;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  int checks   = 0;
  int failures = 0;
  int ft_cnt   = 0;
  int gap      = 0;
  bit was_drive = 1'b0;
  logic [3:0] prev_an = 4'hF;

  seg_scan #(.BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .clr(clr), .segclk(segclk), .enable(enable), .value(value),
    .dp_mask(dp_mask), .blank_lead(blank_lead), .an(an), .seg(seg), .dp(dp),
    .digit_idx(digit_idx), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic push(input logic [3:0] a, input logic [6:0] s, input logic d, input logic [1:0] i);
    exp_t e;
    e.an = a; e.seg = s; e.dp = d; e.idx = i;
    q.push_back(e);
  endtask

  // Monitor: on each digit start pop the expected digit and check the blanking gap.
  always @(negedge clk) begin
    if (frame_tick) ft_cnt++;
    if (an == 4'hF) gap++;
    else if (prev_an == 4'hF) begin
      if (was_drive) chk("blank_gap", gap, BLANK);
      if (q.size() == 0) chk("sb_unexpected_digit", {28'd0, an}, 32'hF);
      else begin
        mon_e = q.pop_front();
        chk("sb_an", an, mon_e.an);
        chk("sb_seg", seg, mon_e.seg);
        chk("sb_dp", dp, mon_e.dp);
        chk("sb_idx", digit_idx, mon_e.idx);
      end
      was_drive = 1'b1;
    end
    if (an != 4'hF) gap = 0;
    if (!clr || !enable) was_drive = 1'b0;
    prev_an = an;
  end

  // One segclk period of 40 clocks; dbl adds a second rising edge inside the gap.
  task automatic step(input bit wrap, input bit dbl);
    int n;
    int ft0;
    @(posedge clk); #1;
    ft0 = ft_cnt;
    segclk = 1'b1;
    n = 0;
    if (dbl) begin
      @(posedge clk); #1 segclk = 1'b0;
      @(posedge clk); #1 segclk = 1'b1;
      n = 2;
    end
    do begin
      @(posedge clk); #1;
      n++;
    end while (an != 4'hF && n < 10);
    chk("tick_latency", n, 3);
    chk("ftick_at_adv", frame_tick, wrap);
    repeat (17) @(posedge clk);
    #1 segclk = 1'b0;
    repeat (20) @(posedge clk);
    chk("ftick_count", ft_cnt - ft0, wrap);
  endtask

  initial begin
    int ft0;
    clr = 1'b0; segclk = 1'b0; enable = 1'b0; value = '0;
    dp_mask = '0; blank_lead = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_idx", digit_idx, 2'd0);
    chk("rst_ftick", frame_tick, 1'b0);
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic scan of 12AF.
    value = 16'h12AF;
    push(4'hE, 7'h0E, 1'b1, 2'd0);
    ft0 = ft_cnt;
    enable = 1'b1;
    repeat (10) @(posedge clk);
    chk("ftick_enable", ft_cnt - ft0, 1);
    push(4'hD, 7'h08, 1'b1, 2'd1); step(0, 0);
    push(4'hB, 7'h24, 1'b1, 2'd2); step(0, 0);
    push(4'h7, 7'h79, 1'b1, 2'd3); step(0, 0);
    push(4'hE, 7'h0E, 1'b1, 2'd0); step(1, 0);

    // A second segclk edge inside the gap must not advance twice.
    push(4'hD, 7'h08, 1'b1, 2'd1); step(0, 1);
    push(4'hB, 7'h24, 1'b1, 2'd2); step(0, 0);
    push(4'h7, 7'h79, 1'b1, 2'd3); step(0, 0);
    push(4'hE, 7'h0E, 1'b1, 2'd0); step(1, 0);

    // Leading-zero blanking and decimal points on 0007.
    value = 16'h0007; blank_lead = 1'b1; dp_mask = 4'b0100;
    push(4'hD, 7'h08, 1'b1, 2'd1); step(0, 0);
    push(4'hB, 7'h24, 1'b0, 2'd2); step(0, 0);
    push(4'h7, 7'h79, 1'b1, 2'd3); step(0, 0);
    push(4'hE, 7'h78, 1'b1, 2'd0); step(1, 0);
    push(4'hD, 7'h7F, 1'b1, 2'd1); step(0, 0);
    push(4'hB, 7'h7F, 1'b0, 2'd2); step(0, 0);
    push(4'h7, 7'h7F, 1'b1, 2'd3); step(0, 0);

    // Mid-frame value change is deferred to the wrap.
    value = 16'h1111; blank_lead = 1'b0; dp_mask = 4'b0000;
    push(4'hE, 7'h79, 1'b1, 2'd0); step(1, 0);
    push(4'hD, 7'h79, 1'b1, 2'd1); step(0, 0);
    value = 16'h2222;
    push(4'hB, 7'h79, 1'b1, 2'd2); step(0, 0);
    push(4'h7, 7'h79, 1'b1, 2'd3); step(0, 0);
    push(4'hE, 7'h24, 1'b1, 2'd0); step(1, 0);
    push(4'hD, 7'h24, 1'b1, 2'd1); step(0, 0);
    push(4'hB, 7'h24, 1'b1, 2'd2); step(0, 0);

    // Drop enable while driving digit 2, then restart.
    @(posedge clk); #1 enable = 1'b0;
    @(posedge clk); #1;
    chk("dis_an", an, 4'hF);
    chk("dis_seg", seg, 7'h7F);
    chk("dis_dp", dp, 1'b1);
    chk("dis_idx", digit_idx, 2'd0);
    repeat (5) @(posedge clk);
    #1;
    push(4'hE, 7'h24, 1'b1, 2'd0);
    ft0 = ft_cnt;
    enable = 1'b1;
    repeat (10) @(posedge clk);
    chk("ftick_reenable", ft_cnt - ft0, 1);
    push(4'hD, 7'h24, 1'b1, 2'd1); step(0, 0);

    // Asynchronous clear mid-drive, restart with a reloaded shadow.
    value = 16'h4321;
    @(posedge clk); #3 clr = 1'b0;
    #1;
    chk("clr_an", an, 4'hF);
    chk("clr_seg", seg, 7'h7F);
    chk("clr_dp", dp, 1'b1);
    chk("clr_idx", digit_idx, 2'd0);
    #10;
    push(4'hE, 7'h79, 1'b1, 2'd0);
    clr = 1'b1;
    repeat (10) @(posedge clk);
    push(4'hD, 7'h24, 1'b1, 2'd1); step(0, 0);
    push(4'hB, 7'h30, 1'b1, 2'd2); step(0, 0);
    push(4'h7, 7'h19, 1'b1, 2'd3); step(0, 0);
    push(4'hE, 7'h79, 1'b1, 2'd0); step(1, 0);

    repeat (5) @(posedge clk);
    #1;
    chk("sb_leftover", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
Name: seg_scan

Overview:
- Four-digit, time-multiplexed 7-segment display driver on the 100 MHz master clock.
- Consumes the raw segclk waveform from the clock divider as a data input: synchronises it, edge-detects it, and advances one digit per segclk rising edge.
- Inserts a programmable blanking gap between digits to suppress ghosting.
- Latches the displayed value only at frame boundaries, so a frame never shows a mix of old and new values.

Parameters:
- BLANK_CYCLES, 16, clk cycles with all anodes off after each digit advance (legal range 1..255).

Ports:
- clk  input  1  master clock, 100 MHz
- clr  input  1  asynchronous, active-low reset
- segclk  input  1  divided scan clock (~381 Hz); asynchronous to clk and sampled as data
- enable  input  1  1 = scanning; 0 = display dark
- value  input  16  four hex digits; value[3:0] is digit 0 (rightmost)
- dp_mask  input  4  decimal-point request per digit, 1 = lit
- blank_lead  input  1  1 = leading-zero blanking
- an  output  4  anodes, active-low, one-hot-low while driving
- seg  output  7  cathodes, active-low, bit order {g,f,e,d,c,b,a}
- dp  output  1  decimal-point cathode, active-low
- digit_idx  output  2  index of the digit currently selected
- frame_tick  output  1  one-cycle pulse when the shadow value is reloaded

Behaviour:
- Reset (clr=0, asynchronous):
  - an=4'hF, seg=7'h7F, dp=1, digit_idx=0, frame_tick=0.
  - Shadow value=0, sync flops=0, state=IDLE, blank counter=0.
- Synchroniser and edge detect:
  - segclk passes through 2 flops (s1, s2), then a history flop s3.
  - tick = s2 & ~s3.
  - tick asserts on the 3rd clk edge after segclk rises (worst case +1 cycle for sampling).
- All outputs are registered; no combinational path from any input to any output.
- Segment decode (hex, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- States: IDLE, BLANK, DRIVE.
- IDLE:
  - an=F, seg=7F, dp=1, digit_idx=0.
  - When enable=1: load shadow from value, pulse frame_tick, load counter with BLANK_CYCLES, go to BLANK.
- BLANK:
  - an=F; the counter decrements each cycle.
  - When the counter reaches 1: next cycle enters DRIVE and drives an[digit_idx]=0 with the decoded seg/dp.
  - Ticks arriving in BLANK are dropped (no queueing, no index advance).
- DRIVE:
  - an = ~(1<<digit_idx).
  - seg = decode(shadow nibble), or 7F if that digit is blanked.
  - dp = ~dp_mask[digit_idx], with dp_mask sampled live.
  - On tick:
    - digit_idx <= digit_idx+1 (mod 4), an <= F, counter <= BLANK_CYCLES, state <= BLANK.
    - On the 3→0 wrap, shadow <= value and frame_tick=1 in that same cycle.
- Leading-zero blanking (blank_lead=1), evaluated on the shadow value:
  - Digit k (k=1..3) is blanked iff shadow nibbles k..3 are all zero.
  - Digit 0 is never blanked.
  - dp is unaffected by blanking.
- enable falling, in any state: next cycle IDLE, with outputs as at reset except the shadow, which is held.
- Simultaneous enable=0 and tick: enable wins.
- value changes mid-frame have no visible effect until the next wrap.
- clr asserted mid-DRIVE forces an=F immediately (asynchronous). Scanning restarts from digit 0 after release.

Test Plan:
- Reset, then enable=1, value=16'h12AF, blank_lead=0, BLANK_CYCLES=4, segclk period 40 clk → frame_tick pulses once; after 4 cycles an=E, seg=0E. On successive ticks: an=D/seg=08, an=B/seg=24, an=7/seg=79. Exactly 4 cycles of an=F separate each digit.
- segclk rising edge in DRIVE → an goes to F exactly 3 clk cycles later; the next digit's anode asserts BLANK_CYCLES cycles after that. A second segclk edge inside BLANK is ignored and digit_idx advances by only 1.
- value=16'h0007, blank_lead=1, dp_mask=4'b0100 → digit 0 shows seg=78. Digits 1 and 3 show seg=7F, dp=1. Digit 2 shows seg=7F, dp=0.
- value changed from 16'h1111 to 16'h2222 while digit_idx=1 → digits 1–3 still show seg=79. Value 2 (seg=24) appears only after the wrap, coincident with frame_tick.
- enable dropped while driving digit 2 → next cycle an=F, seg=7F, digit_idx=0. Re-enable → digit 0 is driven first after BLANK_CYCLES.
- clr pulsed low mid-DRIVE (no clk edge) → an=F, seg=7F, dp=1 asynchronously. After release with enable=1, the scan restarts at digit 0 with shadow reloaded.
